isq_iss: RTL and testbench
==========================

Name: isq_iss

Overview:
- Read/issue side of the issue queue.
- Scans the packed line outputs of all issue-queue lines and selects the lowest-index line that is valid and not waiting.
- Registers the selected instruction into a one-entry output stage, which hands it to the execution unit over a valid/ready handshake.
- Sends one-hot clear pulses back to the lines so each issued entry is freed in the same cycle it is granted.

Parameters:
- INST_WIDTH, 56, instruction payload width per line.
- ISQ_DEPTH, 16, number of queue lines scanned.
- ISQ_IDX_WIDTH, 4, width of the line index (log2 ISQ_DEPTH).
- STALL_CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- isq_lin_flat  input  ISQ_DEPTH*(INST_WIDTH+2)  concatenated lines; line i = bits [(i+1)*(INST_WIDTH+2)-1 : i*(INST_WIDTH+2)]; per line the layout is {brn_wat, wat, inst}.
- lin_val  input  ISQ_DEPTH  per-line valid.
- iss_rdy  input  1  execution unit accepts iss_inst this cycle.
- brn_flush  input  1  mispredict squash.
- brn_resolve  input  1  in-flight branch resolved; used only with the optional feature.
- iss_val  output  1  output stage holds an instruction.
- iss_inst  output  INST_WIDTH  issued instruction.
- iss_idx  output  ISQ_IDX_WIDTH  source line index of iss_inst.
- clr_val_vec  output  ISQ_DEPTH  one-hot grant, drives the lines' clr_val.
- fls_inst_vec  output  ISQ_DEPTH  equal to clr_val_vec, drives the lines' fls_inst.
- stall_cnt  output  STALL_CNT_WIDTH  cycles with iss_val=1 and iss_rdy=0.

Behaviour:
- Reset values: iss_val=0, iss_inst=0, iss_idx=0, stall_cnt=0, internal brn_inflight=0.
- Eligible line i: lin_val[i]=1 and wat=0.
- Output stage free: free = !iss_val | iss_rdy.
- Grant: the lowest eligible index, only when free=1 and brn_flush=0. Otherwise no grant and clr_val_vec=0.
- clr_val_vec / fls_inst_vec: combinational one-hot of the grant in cycle t, so the line clears at the same edge the output stage captures. A line is therefore never granted twice.
- Capture at edge t+1 on grant: iss_val<=1, iss_inst<=line inst, iss_idx<=i. Issue latency is 1 cycle from grant.
- Drain: if iss_val & iss_rdy with no grant, iss_val<=0 and iss_inst/iss_idx hold their values.
- Back-to-back: consume and new grant in the same cycle keeps iss_val=1 with the new payload, giving one issue per cycle at full throughput.
- Stall: iss_val & !iss_rdy holds all outputs stable and increments stall_cnt. stall_cnt saturates at all-ones and never wraps.
- brn_flush: no grant that cycle; iss_val<=0 at the next edge regardless of iss_rdy. Flush has priority over consume and grant. stall_cnt is not cleared.
- No eligible line with free=1: iss_val<=0 if consumed, otherwise unchanged.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); clr_val_vec=0 during reset.

Optional Feature:
- Macro: ISQ_BRN_BLOCK_EN.
- Defined:
  - A line with brn_wat=1 is eligible only when brn_inflight=0.
  - Granting such a line sets brn_inflight<=1.
  - brn_resolve or brn_flush clears brn_inflight. If a grant and a resolve occur in the same cycle, the result is set.
  - Non-branch lines are unaffected, so at most one unresolved branch is in flight.
- Not defined: brn_wat is ignored for eligibility, brn_resolve is unused, and no brn_inflight flop exists.

Test Plan:
- Priority: lin_val=16'h0014, all wat=0, iss_rdy=1 -> cycle t clr_val_vec=16'h0004; next cycle iss_val=1, iss_idx=2; with lin_val updated to 16'h0010, clr_val_vec=16'h0010 the following cycle.
- Wait bit: line 0 wat=1, line 3 wat=0, both valid -> grant line 3, iss_idx=3; line 0 is never granted while wat=1.
- Stall: iss_val=1, iss_rdy=0 for 5 cycles with eligible lines present -> clr_val_vec=0, iss_inst stable, stall_cnt=5; iss_rdy=1 -> next line issued the following cycle.
- Throughput: 4 eligible lines, iss_rdy=1 constantly -> iss_idx sequence 0,1,2,3 on 4 consecutive cycles with iss_val=1 throughout.
- Flush: brn_flush=1 while iss_val=1, iss_rdy=0, eligible lines present -> clr_val_vec=0 that cycle; iss_val=0 next cycle.
- ISQ_BRN_BLOCK_EN: lines 0 and 1 both brn_wat=1 -> line 0 issued, line 1 blocked; brn_resolve pulse -> line 1 granted the next cycle. With the macro undefined, line 1 issues immediately after line 0.

Source files
------------

// File: rtl/isq_iss.sv
// rtl/isq_iss.sv - issue-queue read/issue stage; optional branch blocking via ISQ_BRN_BLOCK_EN
module isq_iss #(
    parameter int INST_WIDTH      = 56,
    parameter int ISQ_DEPTH       = 16,
    parameter int ISQ_IDX_WIDTH   = 4,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ISQ_DEPTH*(INST_WIDTH+2)-1:0] isq_lin_flat,
    input  logic [ISQ_DEPTH-1:0]            lin_val,
    input  logic                            iss_rdy,
    input  logic                            brn_flush,
    input  logic                            brn_resolve,
    output logic                            iss_val,
    output logic [INST_WIDTH-1:0]           iss_inst,
    output logic [ISQ_IDX_WIDTH-1:0]        iss_idx,
    output logic [ISQ_DEPTH-1:0]            clr_val_vec,
    output logic [ISQ_DEPTH-1:0]            fls_inst_vec,
    output logic [STALL_CNT_WIDTH-1:0]      stall_cnt
);
    localparam int LINE_W = INST_WIDTH + 2;

    logic [INST_WIDTH-1:0]    line_inst [ISQ_DEPTH];
    logic [ISQ_DEPTH-1:0]     line_wat;
    logic [ISQ_DEPTH-1:0]     line_brn_wat;
    logic [ISQ_DEPTH-1:0]     elig;
    logic                     free;
    logic                     gnt_any;
    logic [ISQ_IDX_WIDTH-1:0] gnt_idx;
    logic [ISQ_DEPTH-1:0]     gnt_vec;

    // Split each packed line into {brn_wat, wat, inst}
    always_comb begin
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            line_inst[i]    = isq_lin_flat[i*LINE_W +: INST_WIDTH];
            line_wat[i]     = isq_lin_flat[i*LINE_W + INST_WIDTH];
            line_brn_wat[i] = isq_lin_flat[i*LINE_W + INST_WIDTH + 1];
        end
    end

`ifdef ISQ_BRN_BLOCK_EN
    logic brn_inflight;

    // Branch lines are held back while an earlier granted branch is unresolved
    assign elig = lin_val & ~line_wat & ~(line_brn_wat & {ISQ_DEPTH{brn_inflight}});

    // Track the single in-flight branch; a same-cycle grant wins over resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brn_inflight <= 1'b0;
        end else if (gnt_any && line_brn_wat[gnt_idx]) begin
            brn_inflight <= 1'b1;
        end else if (brn_resolve || brn_flush) begin
            brn_inflight <= 1'b0;
        end
    end
`else
    logic unused_brn;

    assign elig       = lin_val & ~line_wat;
    assign unused_brn = ^{brn_resolve, line_brn_wat};
`endif

    assign free = !iss_val || iss_rdy;

    // Lowest-index eligible line wins; nothing is granted on flush, stall or reset
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = ISQ_DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                gnt_any = 1'b1;
                gnt_idx = ISQ_IDX_WIDTH'(i);
            end
        end
        if (!free || brn_flush || !rst_n) begin
            gnt_any = 1'b0;
        end
    end

    assign gnt_vec      = gnt_any ? (ISQ_DEPTH'(1) << gnt_idx) : '0;
    assign clr_val_vec  = gnt_vec;
    assign fls_inst_vec = gnt_vec;

    // Output stage: flush beats grant, grant beats drain; payload holds on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_val  <= 1'b0;
            iss_inst <= '0;
            iss_idx  <= '0;
        end else if (brn_flush) begin
            iss_val <= 1'b0;
        end else if (gnt_any) begin
            iss_val  <= 1'b1;
            iss_inst <= line_inst[gnt_idx];
            iss_idx  <= gnt_idx;
        end else if (iss_rdy) begin
            iss_val <= 1'b0;
        end
    end

    // Saturating count of cycles the execution unit back-pressures a valid issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (iss_val && !iss_rdy && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_isq_iss.sv
// tb/tb_isq_iss.sv - self-checking bench for isq_iss against a line-level model
module tb_isq_iss;
    localparam int IW  = 56;
    localparam int D   = 16;
    localparam int IXW = 4;
    localparam int SCW = 4;
    localparam int LW  = IW + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [D*LW-1:0]   isq_lin_flat = '0;
    logic [D-1:0]      lin_val = '0;
    logic              iss_rdy = 1'b0;
    logic              brn_flush = 1'b0;
    logic              brn_resolve = 1'b0;
    logic              iss_val;
    logic [IW-1:0]     iss_inst;
    logic [IXW-1:0]    iss_idx;
    logic [D-1:0]      clr_val_vec;
    logic [D-1:0]      fls_inst_vec;
    logic [SCW-1:0]    stall_cnt;

    isq_iss #(.INST_WIDTH(IW), .ISQ_DEPTH(D), .ISQ_IDX_WIDTH(IXW), .STALL_CNT_WIDTH(SCW)) dut (
        .clk(clk), .rst_n(rst_n), .isq_lin_flat(isq_lin_flat), .lin_val(lin_val),
        .iss_rdy(iss_rdy), .brn_flush(brn_flush), .brn_resolve(brn_resolve),
        .iss_val(iss_val), .iss_inst(iss_inst), .iss_idx(iss_idx),
        .clr_val_vec(clr_val_vec), .fls_inst_vec(fls_inst_vec), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Bench-side image of the queue lines
    logic          l_val [D];
    logic          l_wat [D];
    logic          l_brn [D];
    logic [IW-1:0] l_inst [D];

    // Model of what the issue stage must hold
    logic          m_val;
    logic [IW-1:0] m_inst;
    int            m_idx;
    int            m_stall;
    logic          m_inflight;
    logic [D-1:0]  last_clr;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if ((m_val && !iss_rdy) || brn_flush) return -1;
        for (int i = 0; i < D; i++) begin
            if (l_val[i] && !l_wat[i]) begin
`ifdef ISQ_BRN_BLOCK_EN
                if (!(l_brn[i] && m_inflight)) return i;
`else
                return i;
`endif
            end
        end
        return -1;
    endfunction

    task automatic clear_lines();
        for (int i = 0; i < D; i++) begin
            l_val[i] = 1'b0; l_wat[i] = 1'b0; l_brn[i] = 1'b0;
            l_inst[i] = 56'({$urandom(), $urandom()});
        end
        brn_flush = 1'b0; brn_resolve = 1'b0; iss_rdy = 1'b1;
    endtask

    task automatic apply_lines();
        for (int i = 0; i < D; i++) begin
            isq_lin_flat[i*LW +: LW] = {l_brn[i], l_wat[i], l_inst[i]};
            lin_val[i] = l_val[i];
        end
    endtask

    // One clock cycle: drive lines, compare, advance the model at the edge
    task automatic step();
        int g;
        logic [D-1:0] exp_clr;
        apply_lines();
        #1;
        g = model_grant();
        exp_clr = (g >= 0) ? (D'(1) << g) : '0;
        last_clr = clr_val_vec;
        chk("clr_val_vec", 64'(clr_val_vec), 64'(exp_clr));
        chk("fls_inst_vec", 64'(fls_inst_vec), 64'(exp_clr));
        chk("iss_val", 64'(iss_val), 64'(m_val));
        chk("iss_inst", 64'(iss_inst), 64'(m_inst));
        chk("iss_idx", 64'(iss_idx), 64'(m_idx));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        @(posedge clk);
        if (m_val && !iss_rdy && m_stall < (1 << SCW) - 1) m_stall++;
`ifdef ISQ_BRN_BLOCK_EN
        if (g >= 0 && l_brn[g]) m_inflight = 1'b1;
        else if (brn_resolve || brn_flush) m_inflight = 1'b0;
`endif
        if (brn_flush) m_val = 1'b0;
        else if (g >= 0) begin
            m_val = 1'b1; m_inst = l_inst[g]; m_idx = g; l_val[g] = 1'b0;
        end else if (iss_rdy) m_val = 1'b0;
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must be zero before any clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst iss_val", 64'(iss_val), 64'd0);
        chk("rst iss_inst", 64'(iss_inst), 64'd0);
        chk("rst iss_idx", 64'(iss_idx), 64'd0);
        chk("rst stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst clr_val_vec", 64'(clr_val_vec), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_val = 1'b0; m_inst = '0; m_idx = 0; m_stall = 0; m_inflight = 1'b0;
        clear_lines();
    endtask

    initial begin
        clear_lines();
        apply_lines();
        @(negedge clk);
        do_reset();

        // Priority: lines 2 and 4
        l_val[2] = 1'b1; l_val[4] = 1'b1;
        step();
        chk("prio clr first", 64'(last_clr), 64'h0004);
        chk("prio iss_val", 64'(iss_val), 64'd1);
        chk("prio iss_idx", 64'(iss_idx), 64'd2);
        step();
        chk("prio clr second", 64'(last_clr), 64'h0010);
        chk("prio iss_idx second", 64'(iss_idx), 64'd4);

        // Wait bit: line 0 waiting, line 3 ready
        do_reset();
        l_val[0] = 1'b1; l_wat[0] = 1'b1; l_val[3] = 1'b1;
        step();
        chk("wat clr", 64'(last_clr), 64'h0008);
        chk("wat iss_idx", 64'(iss_idx), 64'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wat line0 held", 64'(last_clr), 64'h0000);
        end

        // Stall for 5 cycles, then resume with the next line
        do_reset();
        l_val[5] = 1'b1; l_val[6] = 1'b1; l_val[7] = 1'b1;
        step();
        iss_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall clr", 64'(last_clr), 64'h0000);
            chk("stall inst stable", 64'(iss_inst), 64'(l_inst[5]));
        end
        chk("stall_cnt five", 64'(stall_cnt), 64'd5);
        iss_rdy = 1'b1;
        step();
        chk("stall resume clr", 64'(last_clr), 64'h0040);
        chk("stall resume idx", 64'(iss_idx), 64'd6);
        do_reset();

        // Throughput: lines 0..3 back to back
        for (int i = 0; i < 4; i++) l_val[i] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("thru iss_val", 64'(iss_val), 64'd1);
            chk("thru iss_idx", 64'(iss_idx), 64'(k));
        end

        // Flush while stalled
        do_reset();
        l_val[1] = 1'b1; l_val[2] = 1'b1;
        step();
        iss_rdy = 1'b0; brn_flush = 1'b1;
        step();
        chk("flush clr", 64'(last_clr), 64'h0000);
        chk("flush iss_val", 64'(iss_val), 64'd0);
        brn_flush = 1'b0;

        // Branch blocking: two branch lines
        do_reset();
        l_val[0] = 1'b1; l_brn[0] = 1'b1; l_val[1] = 1'b1; l_brn[1] = 1'b1;
        step();
        chk("brn first clr", 64'(last_clr), 64'h0001);
        step();
`ifdef ISQ_BRN_BLOCK_EN
        chk("brn blocked clr", 64'(last_clr), 64'h0000);
        brn_resolve = 1'b1;
        step();
        chk("brn resolve cycle clr", 64'(last_clr), 64'h0000);
        brn_resolve = 1'b0;
        step();
        chk("brn after resolve clr", 64'(last_clr), 64'h0002);
`else
        chk("brn unblocked clr", 64'(last_clr), 64'h0002);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < D; i++) begin
                if (!l_val[i] && ($urandom % 4 == 0)) begin
                    l_val[i] = 1'b1;
                    l_wat[i] = ($urandom % 3 == 0);
                    l_brn[i] = ($urandom % 4 == 0);
                    l_inst[i] = 56'({$urandom(), $urandom()});
                end else if (l_val[i] && l_wat[i] && ($urandom % 3 == 0)) begin
                    l_wat[i] = 1'b0;
                end
            end
            iss_rdy     = ($urandom % 4 != 0);
            brn_flush   = ($urandom % 20 == 0);
            brn_resolve = ($urandom % 8 == 0);
            step();
        end
        brn_flush = 1'b0; brn_resolve = 1'b0;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
